// File: rtl/dmem_port_arbiter.sv
// Single data-memory port arbiter: execute-stage loads vs. committed store-buffer drains.
// Loads win by default; a saturating starvation counter or a full store buffer forces stores through.
module dmem_port_arbiter #(
  parameter int WORD_SIZE_P    = 16,
  parameter int STARVE_LIMIT_P = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   ld_v_i,
  input  logic [WORD_SIZE_P-1:0] ld_addr_i,
  output logic                   ld_ready_o,
  output logic                   ld_resp_v_o,
  output logic [WORD_SIZE_P-1:0] ld_resp_data_o,
  input  logic                   st_v_i,
  input  logic [WORD_SIZE_P-1:0] st_addr_i,
  input  logic [WORD_SIZE_P-1:0] st_data_i,
  output logic                   st_ready_o,
  input  logic                   sb_full_i,
  input  logic                   mispredict_i,
  output logic                   mem_v_o,
  output logic                   mem_w_o,
  output logic [WORD_SIZE_P-1:0] mem_addr_o,
  output logic [WORD_SIZE_P-1:0] mem_w_data_o,
  input  logic [WORD_SIZE_P-1:0] mem_r_data_i
);

  localparam int CW = $clog2(STARVE_LIMIT_P + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT_P);

  // Handshake: a request is accepted in the cycle its valid and ready are both high;
  // an unaccepted requester keeps valid high and retries, nothing is queued here.

  logic          run_q;
  logic [CW-1:0] starve_cnt_q;
  logic [CW-1:0] starve_cnt_d;
  logic          rd_pend_q;
  logic          ld_v;
  logic          st_v;
  logic          force_st;
  logic          st_gnt;
  logic          ld_gnt;

  // run_q holds every output at zero from reset assertion until the first clock after release.
  assign ld_v     = ld_v_i & run_q;
  assign st_v     = st_v_i & run_q;
  assign force_st = st_v & (sb_full_i | (starve_cnt_q == LIMIT));
  assign st_gnt   = st_v & (force_st | ~ld_v | mispredict_i);
  assign ld_gnt   = ld_v & ~st_gnt & ~mispredict_i;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!st_v || st_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      run_q        <= 1'b0;
      starve_cnt_q <= '0;
      rd_pend_q    <= 1'b0;
    end else begin
      run_q        <= 1'b1;
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= ld_gnt & ~mispredict_i;
    end
  end

  assign ld_ready_o     = ld_gnt;
  assign st_ready_o     = st_gnt;
  assign mem_v_o        = st_gnt | ld_gnt;
  assign mem_w_o        = st_gnt;
  assign mem_addr_o     = run_q ? (st_gnt ? st_addr_i : ld_addr_i) : '0;
  assign mem_w_data_o   = run_q ? st_data_i : '0;
  // A flush in the response cycle kills the load that was granted the cycle before.
  assign ld_resp_v_o    = rd_pend_q & ~mispredict_i;
  assign ld_resp_data_o = run_q ? mem_r_data_i : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios then random traffic, checked by a
// cycle-stamped scoreboard fed from a behavioural arbitration/memory model.
module tb_dmem_port_arbiter;

  localparam int W     = 16;
  localparam int LIMIT = 4;
  localparam int EW    = 16 + 1 + W + W;
  localparam int RW    = 16 + W;

  // clock / reset
  logic clk = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         ld_v_i = 1'b0;
  logic [W-1:0] ld_addr_i = '0;
  logic         ld_ready_o;
  logic         ld_resp_v_o;
  logic [W-1:0] ld_resp_data_o;
  logic         st_v_i = 1'b0;
  logic [W-1:0] st_addr_i = '0;
  logic [W-1:0] st_data_i = '0;
  logic         st_ready_o;
  logic         sb_full_i = 1'b0;
  logic         mispredict_i = 1'b0;
  logic         mem_v_o;
  logic         mem_w_o;
  logic [W-1:0] mem_addr_o;
  logic [W-1:0] mem_w_data_o;
  logic [W-1:0] mem_r_data_i = 16'hA5A5;

  dmem_port_arbiter #(.WORD_SIZE_P(W), .STARVE_LIMIT_P(LIMIT)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .ld_v_i(ld_v_i), .ld_addr_i(ld_addr_i), .ld_ready_o(ld_ready_o),
    .ld_resp_v_o(ld_resp_v_o), .ld_resp_data_o(ld_resp_data_o),
    .st_v_i(st_v_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_ready_o(st_ready_o),
    .sb_full_i(sb_full_i), .mispredict_i(mispredict_i),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_w_data_o(mem_w_data_o), .mem_r_data_i(mem_r_data_i)
  );

  // synchronous memory behind the port
  logic [W-1:0] env_mem [32] = '{default: 16'h0};
  always @(posedge clk) begin
    if (mem_v_o) begin
      if (mem_w_o) env_mem[mem_addr_o[4:0]] <= mem_w_data_o;
      else         mem_r_data_i <= env_mem[mem_addr_o[4:0]];
    end
  end

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [RW-1:0] resp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic fail(input string name, input logic [63:0] got, input logic [63:0] want);
    errors++;
    $display("FAIL %s at cycle %0d: got=%h expected=%h", name, cyc, got, want);
  endtask

  // behavioural model: arbitration rules, blocked-cycle count and memory image
  logic [W-1:0] model_mem [32] = '{default: 16'h0};
  bit           m_run = 0;
  bit           m_pend = 0;
  logic [W-1:0] m_pend_data = '0;
  int           m_blocked = 0;
  bit           m_st_gnt = 0;

  // driver: one clock cycle of stimulus, model update and expectation push
  task automatic do_cycle(input bit lv, input logic [W-1:0] la, input bit sv,
                          input logic [W-1:0] sa, input logic [W-1:0] sd,
                          input bit full, input bit mis);
    bit fst, sg, lg;
    @(posedge clk);
    if (reset_i) m_run = 1;
    #1;
    ld_v_i = lv; ld_addr_i = la; st_v_i = sv; st_addr_i = sa; st_data_i = sd;
    sb_full_i = full; mispredict_i = mis;
    if (m_pend && m_run && !mis) resp_q.push_back({cyc[15:0], m_pend_data});
    m_pend = 0;
    m_st_gnt = 0;
    if (m_run) begin
      fst = sv && (full || m_blocked >= LIMIT);
      sg  = sv && (fst || !lv || mis);
      lg  = lv && !sg && !mis;
      if (sg) begin
        exp_q.push_back({cyc[15:0], 1'b1, sa, sd});
        model_mem[sa[4:0]] = sd;
      end else if (lg) begin
        exp_q.push_back({cyc[15:0], 1'b0, la, 16'h0});
        m_pend = 1;
        m_pend_data = model_mem[la[4:0]];
      end
      m_blocked = (sv && !sg) ? m_blocked + 1 : 0;
      m_st_gnt = sg;
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [52:0] outs;
    outs = {ld_ready_o, ld_resp_v_o, ld_resp_data_o, st_ready_o, mem_v_o, mem_w_o,
            mem_addr_o, mem_w_data_o};
    checks++;
    if (outs !== '0) fail(name, 64'(outs), 64'h0);
  endtask

  // monitor: compares DUT port activity against the expected queues
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    logic [RW-1:0] r;
    if (mem_v_o) begin
      checks++;
      got = {cyc[15:0], mem_w_o, mem_addr_o, (mem_w_o ? mem_w_data_o : 16'h0)};
      if (exp_q.size() == 0) fail("mem_unexpected", 64'(got), 64'h0);
      else begin
        e = exp_q.pop_front();
        if (got !== e) fail("mem_access", 64'(got), 64'(e));
      end
      checks++;
      if ({ld_ready_o, st_ready_o} !== {~mem_w_o, mem_w_o})
        fail("ready_vs_mem", 64'({ld_ready_o, st_ready_o}), 64'({~mem_w_o, mem_w_o}));
    end else begin
      if (exp_q.size() != 0 && exp_q[0][EW-1 -: 16] == cyc[15:0]) begin
        checks++;
        e = exp_q.pop_front();
        fail("mem_missing", 64'h0, 64'(e));
      end
      if (ld_ready_o || st_ready_o) begin
        checks++;
        fail("ready_without_mem", 64'({ld_ready_o, st_ready_o}), 64'h0);
      end
    end
    if (ld_resp_v_o) begin
      checks++;
      got = '0;
      r = {cyc[15:0], ld_resp_data_o};
      if (resp_q.size() == 0) fail("resp_unexpected", 64'(r), 64'h0);
      else begin
        got[RW-1:0] = resp_q.pop_front();
        if (r !== got[RW-1:0]) fail("ld_resp", 64'(r), 64'(got[RW-1:0]));
      end
    end else if (resp_q.size() != 0 && resp_q[0][RW-1 -: 16] == cyc[15:0]) begin
      checks++;
      r = resp_q.pop_front();
      fail("resp_missing", 64'h0, 64'(r));
    end
  end

  // stimulus
  initial begin
    bit           cur_sv;
    logic [W-1:0] cur_sa, cur_sd;

    // reset state with active-looking inputs
    ld_v_i = 1; st_v_i = 1; st_addr_i = 16'h0003; st_data_i = 16'h1111; ld_addr_i = 16'h0004;
    #2 check_all_zero("reset_outputs_t0");
    @(negedge clk) check_all_zero("reset_outputs_hold");
    @(posedge clk); #3 reset_i = 1;
    ld_v_i = 0; st_v_i = 0;

    // store alone, then load of the same address
    do_cycle(0, 16'h0000, 1, 16'h0010, 16'hBEEF, 0, 0);
    do_cycle(1, 16'h0010, 0, 16'h0000, 16'h0000, 0, 0);
    do_cycle(0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);

    // starvation: store pending under continuous loads, then loads resume
    for (int i = 0; i < 5; i++) do_cycle(1, 16'(i), 1, 16'h0005, 16'h1234, 0, 0);
    for (int i = 0; i < 2; i++) do_cycle(1, 16'h0005, 0, 16'h0000, 16'h0000, 0, 0);

    // store buffer full forces the store immediately
    do_cycle(1, 16'h0002, 1, 16'h0007, 16'h7777, 1, 0);
    do_cycle(1, 16'h0007, 0, 16'h0000, 16'h0000, 0, 0);

    // flush: load granted, then mispredict with a store and new load pending
    do_cycle(1, 16'h0010, 0, 16'h0000, 16'h0000, 0, 0);
    do_cycle(1, 16'h0003, 1, 16'h0008, 16'h8888, 0, 1);
    do_cycle(0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);

    // async reset with rd_pend set and starvation counter at 3
    for (int i = 0; i < 3; i++) do_cycle(1, 16'h0010, 1, 16'h0009, 16'h9999, 0, 0);
    @(posedge clk); #1;
    ld_v_i = 1; st_v_i = 1;
    #2 reset_i = 0;
    m_run = 0; m_pend = 0; m_blocked = 0;
    #1 check_all_zero("async_reset_immediate");
    @(negedge clk) check_all_zero("async_reset_hold");
    @(posedge clk); #3 reset_i = 1;
    for (int i = 0; i < 5; i++) do_cycle(1, 16'h0009, 1, 16'h0009, 16'h9999, 0, 0);
    do_cycle(1, 16'h0009, 0, 16'h0000, 16'h0000, 0, 0);

    // randomized traffic; store held stable until granted
    cur_sv = 0; cur_sa = '0; cur_sd = '0;
    for (int i = 0; i < 600; i++) begin
      if (!cur_sv && $urandom_range(0, 2) == 0) begin
        cur_sv = 1;
        cur_sa = 16'($urandom_range(0, 31));
        cur_sd = 16'($urandom);
      end
      do_cycle($urandom_range(0, 3) != 0, 16'($urandom_range(0, 31)), cur_sv, cur_sa, cur_sd,
               $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      if (m_st_gnt) cur_sv = 0;
    end
    do_cycle(0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
    do_cycle(0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
    @(negedge clk); #1;

    // report
    checks++;
    if (exp_q.size() != 0) fail("exp_q_drained", 64'(exp_q.size()), 64'h0);
    checks++;
    if (resp_q.size() != 0) fail("resp_q_drained", 64'(resp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
